// File: rtl/mem_arbiter_pkg.sv
// Shared memory-access types for the suro-v core and the memory arbiter.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_addr_t;

    typedef struct packed {
        logic      we;
        word_t     addr;
        mem_addr_t size;
        word_t     wdata;
    } mem_req_t;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int fifoPtrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Small request FIFO; full and empty are told apart by the pointer wrap bit.
module mem_req_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  logic     pop_i,
    input  mem_req_t data_i,
    output mem_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifoPtrWidth(DEPTH);

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    mem_req_t      mem_q [DEPTH];
    logic          doPush, doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q[AW-1:0]];

    // Advance each pointer by one when its side of the FIFO moves.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + PW'(1);
        if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    end

    // Pointer registers; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset since the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core (absolute priority, combinational
// pass-through) and a queued secondary requester that only uses idle cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 64,
    parameter int CNT_W        = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  word_t     c_addr,
    input  logic      c_rden,
    input  logic      c_wren,
    input  mem_addr_t c_size,
    input  word_t     c_wdata,
    output word_t     c_rdata,
    input  logic      s_req_valid,
    output logic      s_req_ready,
    input  logic      s_req_we,
    input  word_t     s_req_addr,
    input  mem_addr_t s_req_size,
    input  word_t     s_req_wdata,
    output logic      s_rsp_valid,
    output word_t     s_rsp_data,
    output word_t     m_addr,
    output logic      m_rden,
    output logic      m_wren,
    output mem_addr_t m_size,
    output word_t     m_wdata,
    input  word_t     m_rdata,
    output logic      starve,
    output logic      s_busy
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             coreAct, issue, fifoFull, fifoEmpty, push;
    mem_req_t         reqIn, head;
    logic             rdPend_q, rdPend_d;
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

    assign coreAct = c_rden | c_wren;
    assign issue   = !coreAct && !fifoEmpty;
    assign push    = s_req_valid && !fifoFull;
    assign reqIn   = '{we: s_req_we, addr: s_req_addr, size: s_req_size, wdata: s_req_wdata};

    mem_req_fifo #(.DEPTH(DEPTH)) reqFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (issue),
        .data_i  (reqIn),
        .head_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Core passes straight through; the queue head only drives an idle port.
    always_comb begin
        m_addr  = c_addr;
        m_rden  = c_rden;
        m_wren  = c_wren;
        m_size  = c_size;
        m_wdata = c_wdata;
        if (issue) begin
            m_addr  = head.addr;
            m_rden  = !head.we;
            m_wren  = head.we;
            m_size  = head.size;
            m_wdata = head.wdata;
        end
    end

    // Remember a secondary read so its data is flagged the following cycle.
    always_comb begin
        rdPend_d = issue && !head.we;
    end

    // Count cycles the waiting head is blocked by the core, saturating.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (issue || fifoEmpty) begin
            starveCnt_d = '0;
        end else if (coreAct && starveCnt_q != LIMIT) begin
            starveCnt_d = starveCnt_q + CNT_W'(1);
        end
    end

    // Response flag and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPend_q    <= 1'b0;
            starveCnt_q <= '0;
        end else begin
            rdPend_q    <= rdPend_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    assign s_req_ready = !fifoFull;
    assign s_rsp_valid = rdPend_q;
    assign s_rsp_data  = m_rdata;
    assign c_rdata     = m_rdata;
    assign starve      = (starveCnt_q == LIMIT);
    assign s_busy      = !fifoEmpty || rdPend_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pass-through table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 64;

    logic      clk = 1'b0;
    logic      rst;
    word_t     cAddr, cWdata, cRdata;
    logic      cRden, cWren;
    mem_addr_t cSize;
    logic      sValid, sReady, sWe;
    word_t     sAddr, sWdata;
    mem_addr_t sSize;
    logic      rspValid;
    word_t     rspData;
    word_t     mAddr, mWdata, mRdata;
    logic      mRden, mWren;
    mem_addr_t mSize;
    logic      starve, sBusy;

    int checks = 0;
    int errors = 0;

    mem_req_t mq[$];
    bit       pendRd;
    word_t    pendData;
    bit       pendCore;
    word_t    pendCoreData;
    int       cnt;
    bit       lastAccepted;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .c_addr(cAddr), .c_rden(cRden), .c_wren(cWren), .c_size(cSize),
        .c_wdata(cWdata), .c_rdata(cRdata),
        .s_req_valid(sValid), .s_req_ready(sReady), .s_req_we(sWe),
        .s_req_addr(sAddr), .s_req_size(sSize), .s_req_wdata(sWdata),
        .s_rsp_valid(rspValid), .s_rsp_data(rspData),
        .m_addr(mAddr), .m_rden(mRden), .m_wren(mWren), .m_size(mSize),
        .m_wdata(mWdata), .m_rdata(mRdata),
        .starve(starve), .s_busy(sBusy)
    );

    function automatic word_t memFn(input word_t a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    // Synchronous memory: read data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (mRden) mRdata <= memFn(mAddr);
        else       mRdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input word_t ca,
                                 input bit sv, input bit swe, input word_t sa);
        cRden  = rd;
        cWren  = wr;
        cAddr  = ca;
        cSize  = mem_addr_t'(ca[1:0]);
        cWdata = ~ca;
        sValid = sv;
        sWe    = swe;
        sAddr  = sa;
        sSize  = mem_addr_t'(sa[3:2]);
        sWdata = sa ^ 32'h5A5A0000;
    endtask

    // Compare every observable output with what the model predicts.
    task automatic checkOutput();
        bit       coreAct;
        mem_req_t h;
        #1;
        coreAct = cRden | cWren;
        if (coreAct) begin
            chk("coreAddr",  mAddr,  cAddr);
            chk("coreRden",  mRden,  cRden);
            chk("coreWren",  mWren,  cWren);
            chk("coreSize",  mSize,  cSize);
            chk("coreWdata", mWdata, cWdata);
        end else if (mq.size() > 0) begin
            h = mq[0];
            chk("issAddr",  mAddr,  h.addr);
            chk("issRden",  mRden,  !h.we);
            chk("issWren",  mWren,  h.we);
            chk("issSize",  mSize,  h.size);
            chk("issWdata", mWdata, h.wdata);
        end else begin
            chk("idleRden", mRden, 0);
            chk("idleWren", mWren, 0);
        end
        chk("ready",    sReady,   mq.size() < DEPTH);
        chk("rspValid", rspValid, pendRd);
        if (pendRd) chk("rspData", rspData, pendData);
        chk("starve",   starve,   cnt == LIMIT);
        chk("busy",     sBusy,    (mq.size() > 0) || pendRd);
        if (pendCore) chk("coreRdata", cRdata, pendCoreData);
    endtask

    // Clock edge: update the model from the rules, then return to the negedge.
    task automatic advance();
        int       pre;
        bit       iss;
        bit       coreAct;
        mem_req_t h;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            pendRd = 0; pendCore = 0; cnt = 0; lastAccepted = 0;
        end else begin
            coreAct = cRden | cWren;
            pre     = mq.size();
            iss     = !coreAct && pre > 0;
            if (iss) h = mq[0];
            if (iss || pre == 0) cnt = 0;
            else if (coreAct && cnt < LIMIT) cnt++;
            pendRd       = iss && !h.we;
            pendData     = memFn(h.addr);
            pendCore     = cRden;
            pendCoreData = memFn(cAddr);
            if (iss) void'(mq.pop_front());
            lastAccepted = sValid && pre < DEPTH;
            if (lastAccepted)
                mq.push_back('{we: sWe, addr: sAddr, size: sSize, wdata: sWdata});
        end
        @(negedge clk);
    endtask

    task automatic step(input bit rd, input bit wr, input word_t ca,
                        input bit sv, input bit swe, input word_t sa);
        applyStimulus(rd, wr, ca, sv, swe, sa);
        checkOutput();
        advance();
    endtask

    typedef struct {
        bit    rd, wr;
        word_t addr;
        bit    expRd, expWr;
        word_t expAddr, expWdata;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{rd: 1, wr: 0, addr: 32'h40, expRd: 1, expWr: 0, expAddr: 32'h40, expWdata: 32'hFFFFFFBF};
        vecs[1] = '{rd: 0, wr: 1, addr: 32'h84, expRd: 0, expWr: 1, expAddr: 32'h84, expWdata: 32'hFFFFFF7B};
        vecs[2] = '{rd: 1, wr: 1, addr: 32'hC0, expRd: 1, expWr: 1, expAddr: 32'hC0, expWdata: 32'hFFFFFF3F};
        vecs[3] = '{rd: 0, wr: 0, addr: 32'h10, expRd: 0, expWr: 0, expAddr: 32'h10, expWdata: 32'hFFFFFFEF};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        mq.delete(); pendRd = 0; pendCore = 0; cnt = 0; lastAccepted = 0;
        repeat (2) @(negedge clk);
        checkOutput();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] core pass-through table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, 0, 0, 0);
            #1;
            chk("tblRden",  mRden,  vecs[i].expRd);
            chk("tblWren",  mWren,  vecs[i].expWr);
            chk("tblAddr",  mAddr,  vecs[i].expAddr);
            chk("tblWdata", mWdata, vecs[i].expWdata);
            advance();
        end

        $display("[TB] single secondary read");
        step(0, 0, 0, 1, 0, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("t1Rden", mRden, 1);
        chk("t1Addr", mAddr, 32'h100);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("t1RspValid", rspValid, 1);
        chk("t1RspData",  rspData,  32'hDEADBEEF);
        advance();

        $display("[TB] starvation");
        step(1, 0, 32'h40, 1, 1, 32'h200);
        for (int i = 0; i < LIMIT; i++) step(1, 0, 32'h40, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("t2Starve", starve, 1);
        chk("t2Wren",   mWren,  1);
        chk("t2Addr",   mAddr,  32'h200);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("t2StarveDrop", starve, 0);
        advance();

        $display("[TB] full queue ordering");
        step(1, 0, 32'h48, 1, 0, 32'hA00);
        step(1, 0, 32'h48, 1, 0, 32'hB00);
        applyStimulus(1, 0, 32'h48, 1, 0, 32'hC00);
        checkOutput();
        chk("t3ReadyFull", sReady, 0);
        advance();
        step(0, 0, 0, 1, 0, 32'hC00);
        step(0, 0, 0, 1, 0, 32'hC00);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("t3IssueC", mAddr, 32'hC00);
        advance();
        step(0, 0, 0, 0, 0, 0);

        $display("[TB] secondary read then core read");
        step(0, 0, 0, 1, 0, 32'h300);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 32'h44, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("[TB] reset mid-operation");
        step(1, 0, 32'h40, 1, 0, 32'h500);
        step(1, 0, 32'h40, 1, 0, 32'h504);
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        mq.delete(); pendRd = 0; pendCore = 0; cnt = 0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("rstRspValid", rspValid, 0);
        chk("rstReady",    sReady,   1);
        chk("rstBusy",     sBusy,    0);
        advance();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("rstNoIssue", mRden, 0);
        advance();

        $display("[TB] alternating core and idle cycles");
        for (int i = 0; i < 16; i++)
            step(i % 2 == 0, 0, 32'h60, (i < 8), 0, 32'h700 + 32'(i / 2) * 4);

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            bit    rd, wr, sv, swe;
            word_t sa;
            rd = 0; wr = 0;
            if ($urandom_range(0, 99) < 55) begin
                if ($urandom_range(0, 1) == 1) rd = 1;
                else wr = 1;
            end
            if (sValid && !lastAccepted) begin
                sv = 1; swe = sWe; sa = sAddr;
            end else begin
                sv  = ($urandom_range(0, 99) < 40);
                swe = $urandom_range(0, 1) == 1;
                sa  = $urandom;
            end
            step(rd, wr, $urandom, sv, swe, sa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
